// File: rtl/stopwatch_ctrl_if.sv
// Purpose: groups the stopwatch controller's button, alarm and datapath-control signals.
// Latency: none; this is a plain bundle of wires.
// Backpressure: none; every signal is a level or a single-cycle pulse.
interface stopwatch_ctrl_if;
    logic       btn_start;
    logic       btn_lap;
    logic       btn_clear;
    logic       alarm_evt;
    logic       count_en;
    logic       count_clr;
    logic       disp_hold;
    logic [1:0] state;
    logic       buzzer;

    // Board/datapath side: drives the raw buttons and alarm, consumes the controls.
    modport master (
        output btn_start, btn_lap, btn_clear, alarm_evt,
        input  count_en, count_clr, disp_hold, state, buzzer
    );

    // Controller side.
    modport slave (
        input  btn_start, btn_lap, btn_clear, alarm_evt,
        output count_en, count_clr, disp_hold, state, buzzer
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Purpose: debounces the three stopwatch buttons, runs the start/pause/split/clear FSM and the buzzer sequencer.
// Latency: raw press to internal pulse is 2 + DEBOUNCE_CYCLES cycles; all outputs registered one edge later.
// Backpressure: none; presses that are illegal or lose same-cycle priority are dropped. Optional macro STOPWATCH_AUTOSTOP_EN.
module stopwatch_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int BEEP_CYCLES     = 25000000,
    parameter int BEEP_COUNT      = 3
) (
    input  logic             clk,
    input  logic             reset,
    stopwatch_ctrl_if.slave  sw_if
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        SPLIT = 2'b10,
        PAUSE = 2'b11
    } state_t;

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int PW = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] PH_LAST   = PW'(BEEP_CYCLES - 1);
    localparam logic [3:0]    BEEP_LAST = 4'(BEEP_COUNT - 1);

    // Button bit order everywhere: [0] start, [1] lap, [2] clear.
    logic [2:0]    r_sync1;
    logic [2:0]    r_sync2;
    logic [2:0]    r_db_lvl;
    logic [2:0]    r_db_prev;
    logic [DW-1:0] r_db_cnt [3];
    logic [2:0]    w_press;
    logic          w_start;
    logic          w_lap;
    logic          w_clear;

    state_t        r_state;
    state_t        w_next;
    logic          w_clr_act;
    logic          r_count_en;
    logic          r_count_clr;
    logic          r_disp_hold;

    logic          r_bz_active;
    logic          r_buzzer;
    logic [PW-1:0] r_phase;
    logic [3:0]    r_beep;
    logic          w_alarm_acc;

    // Two-flop synchronizer for the asynchronous raw buttons.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {sw_if.btn_clear, sw_if.btn_lap, sw_if.btn_start};
            r_sync2 <= r_sync1;
        end
    end

    // Debounce: flip the accepted level only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_db_lvl  <= '0;
            r_db_prev <= '0;
            for (int b = 0; b < 3; b++) begin
                r_db_cnt[b] <= '0;
            end
        end else begin
            r_db_prev <= r_db_lvl;
            for (int b = 0; b < 3; b++) begin
                if (r_sync2[b] == r_db_lvl[b]) begin
                    r_db_cnt[b] <= '0;
                end else if (r_db_cnt[b] == DB_LAST) begin
                    r_db_lvl[b] <= r_sync2[b];
                    r_db_cnt[b] <= '0;
                end else begin
                    r_db_cnt[b] <= r_db_cnt[b] + DW'(1);
                end
            end
        end
    end

    // A press is the rising edge of the debounced level; releases are ignored.
    assign w_press = r_db_lvl & ~r_db_prev;
    assign w_start = w_press[0];
    assign w_lap   = w_press[1];
    assign w_clear = w_press[2];

    // The alarm only counts while the counters run and no beep sequence is in progress.
    assign w_alarm_acc = sw_if.alarm_evt & r_count_en & ~r_bz_active;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state: per state, only the highest-priority legal press acts (clear > start > lap).
    always_comb begin
        w_next    = r_state;
        w_clr_act = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_clear) begin
                    w_clr_act = 1'b1;
                end else if (w_start) begin
                    w_next = RUN;
                end
            end
            RUN: begin
                if (w_start) begin
                    w_next = PAUSE;
                end else if (w_lap) begin
                    w_next = SPLIT;
                end
            end
            SPLIT: begin
                if (w_start) begin
                    w_next = PAUSE;
                end else if (w_lap) begin
                    w_next = RUN;
                end
            end
            PAUSE: begin
                if (w_clear) begin
                    w_clr_act = 1'b1;
                    w_next    = IDLE;
                end else if (w_start) begin
                    w_next = RUN;
                end
            end
            default: w_next = IDLE;
        endcase
`ifdef STOPWATCH_AUTOSTOP_EN
        // An accepted alarm implies RUN or SPLIT and overrides any press this cycle.
        if (w_alarm_acc) begin
            w_next = PAUSE;
        end
`endif
    end

    // Registered datapath controls, decoded from the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count_en  <= 1'b0;
            r_disp_hold <= 1'b0;
            r_count_clr <= 1'b0;
        end else begin
            r_count_en  <= (w_next == RUN) || (w_next == SPLIT);
            r_disp_hold <= (w_next == SPLIT);
            r_count_clr <= w_clr_act;
        end
    end

    // Buzzer sequencer: BEEP_COUNT on/off pairs of BEEP_CYCLES each; an acting clear aborts it.
    always_ff @(posedge clk) begin
        if (reset || w_clr_act) begin
            r_bz_active <= 1'b0;
            r_buzzer    <= 1'b0;
            r_phase     <= '0;
            r_beep      <= '0;
        end else if (w_alarm_acc) begin
            r_bz_active <= 1'b1;
            r_buzzer    <= 1'b1;
            r_phase     <= '0;
            r_beep      <= '0;
        end else if (r_bz_active) begin
            if (r_phase == PH_LAST) begin
                r_phase <= '0;
                if (r_buzzer) begin
                    r_buzzer <= 1'b0;
                end else if (r_beep == BEEP_LAST) begin
                    r_bz_active <= 1'b0;
                    r_beep      <= '0;
                end else begin
                    r_beep   <= r_beep + 4'd1;
                    r_buzzer <= 1'b1;
                end
            end else begin
                r_phase <= r_phase + PW'(1);
            end
        end
    end

    assign sw_if.count_en  = r_count_en;
    assign sw_if.count_clr = r_count_clr;
    assign sw_if.disp_hold = r_disp_hold;
    assign sw_if.state     = r_state;
    assign sw_if.buzzer    = r_buzzer;

endmodule
